// File: rtl/strobe_gen_pkg.sv
// Shared constants and elaboration helpers for the strobe generator.
// Default divisors are the transmitter filter, pilot and frame rates.
package strobe_gen_pkg;

  localparam int unsigned DIV_FILT  = 32'd41;
  localparam int unsigned DIV_PILOT = 32'd40;
  localparam int unsigned DIV_FRAME = 32'd164;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd32; i++) begin
      if ((32'd1 << i) < v) r = i + 32'd1;
    end
    return r;
  endfunction

  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : clog2(n);
  endfunction

endpackage

// File: rtl/strobe_gen_div_ch.sv
// One strobe channel: modulo counter over the active divisor, strobe flop,
// and a load port that swaps the divisor only at a period boundary or on sync.
module strobe_div_ch #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(40)
) (
  input  logic             clk,
  input  logic             rst_clk,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_div,
  output logic             o_wrap,
  output logic             o_strb
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic             r_strb;

  // Divisors 0 and 1 both collapse to a period of one cycle.
  function automatic logic [CNT_W-1:0] last_of(input logic [CNT_W-1:0] d);
    return (d <= CNT_W'(1)) ? {CNT_W{1'b0}} : d - CNT_W'(1);
  endfunction

  assign o_wrap = i_en && (r_cnt >= last_of(r_div));
  assign o_strb = r_strb;

  // Counter, active divisor and strobe; sync outranks enable.
  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      r_cnt  <= last_of(DIV_RST);
      r_div  <= DIV_RST;
      r_strb <= 1'b0;
    end else if (i_sync || o_wrap) begin
      r_cnt  <= {CNT_W{1'b0}};
      r_strb <= 1'b1;
      if (i_load) begin
        r_div <= i_load_div;
      end else begin
        r_div <= r_div;
      end
    end else if (i_en) begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_strb <= 1'b0;
    end else begin
      r_strb <= 1'b0;
    end
  end

endmodule

// File: rtl/strobe_gen.sv
// Multi-channel strobe generator: one strobe_div_ch per channel, a single-entry
// divisor update slot with valid/ready handshake, and the all-channel coincidence flag.
module strobe_gen
  import strobe_gen_pkg::*;
#(
  parameter int                    N_CH     = 3,
  parameter int                    CNT_W    = 8,
  parameter logic [N_CH*CNT_W-1:0] DIV_INIT = {CNT_W'(DIV_PILOT), CNT_W'(DIV_FILT), CNT_W'(DIV_FRAME)},
  localparam int                   CH_W     = int'(ch_width(N_CH))
) (
  input  logic             clk,
  input  logic             rst_clk,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [CH_W-1:0]  i_cfg_ch,
  input  logic [CNT_W-1:0] i_cfg_div,
  output logic             o_cfg_err,
  output logic [N_CH-1:0]  o_strb,
  output logic             o_strb_all
);

  localparam logic [CH_W:0] N_CH_W = (CH_W + 1)'(N_CH);

  logic             r_pend_valid;
  logic [CH_W-1:0]  r_pend_ch;
  logic [CNT_W-1:0] r_pend_div;
  logic             r_cfg_ready;
  logic             r_cfg_err;

  logic [N_CH-1:0]  w_sel;
  logic [N_CH-1:0]  w_wrap;
  logic [N_CH-1:0]  w_strb;
  logic             w_xfer;
  logic             w_ch_ok;
  logic             w_commit;

  assign w_xfer   = i_cfg_valid && r_cfg_ready;
  assign w_ch_ok  = ({1'b0, i_cfg_ch} < N_CH_W);
  // The slot empties when its channel wraps or when sync forces the load.
  assign w_commit = |(w_sel & (w_wrap | {N_CH{i_sync}}));

  // Pending slot and handshake; ready reopens one edge after the slot empties.
  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      r_pend_valid <= 1'b0;
      r_pend_ch    <= {CH_W{1'b0}};
      r_pend_div   <= {CNT_W{1'b0}};
      r_cfg_ready  <= 1'b1;
      r_cfg_err    <= 1'b0;
    end else begin
      r_cfg_err <= w_xfer && !w_ch_ok;
      if (w_xfer && w_ch_ok) begin
        r_pend_valid <= 1'b1;
        r_pend_ch    <= i_cfg_ch;
        r_pend_div   <= i_cfg_div;
        r_cfg_ready  <= 1'b0;
      end else if (w_commit) begin
        r_pend_valid <= 1'b0;
        r_cfg_ready  <= 1'b0;
      end else begin
        r_cfg_ready  <= !r_pend_valid;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign w_sel[g] = r_pend_valid && (r_pend_ch == CH_W'(g));

    strobe_div_ch #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_INIT[g*CNT_W +: CNT_W])
    ) u_ch (
      .clk        (clk),
      .rst_clk    (rst_clk),
      .i_en       (i_en),
      .i_sync     (i_sync),
      .i_load     (w_sel[g]),
      .i_load_div (r_pend_div),
      .o_wrap     (w_wrap[g]),
      .o_strb     (w_strb[g])
    );
  end

  assign o_strb      = w_strb;
  assign o_strb_all  = &w_strb;
  assign o_cfg_ready = r_cfg_ready;
  assign o_cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_strobe_gen.sv
// Directed bench for strobe_gen with default divisors 164/41/40: table of
// recorded strobe cycles after reset plus hand-written multi-cycle sequences.
module tb_strobe_gen;

  localparam int N_CH  = 3;
  localparam int CNT_W = 8;
  localparam int CH_W  = 2;

  logic             clk;
  logic             rst_clk;
  logic             i_en;
  logic             i_sync;
  logic             i_cfg_valid;
  logic             o_cfg_ready;
  logic [CH_W-1:0]  i_cfg_ch;
  logic [CNT_W-1:0] i_cfg_div;
  logic             o_cfg_err;
  logic [N_CH-1:0]  o_strb;
  logic             o_strb_all;

  strobe_gen #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_clk     (rst_clk),
    .i_en        (i_en),
    .i_sync      (i_sync),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_cfg_ch    (i_cfg_ch),
    .i_cfg_div   (i_cfg_div),
    .o_cfg_err   (o_cfg_err),
    .o_strb      (o_strb),
    .o_strb_all  (o_strb_all)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] strb;
  } vec_t;

  vec_t       tbl [14];
  logic [2:0] obs [1:1641];
  int         n_pass;
  int         n_checks;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic next_strb(input int ch, input int bound, output int d);
    d = 0;
    for (int k = 1; k <= bound; k++) begin
      step();
      if (o_strb[ch]) begin
        d = k;
        break;
      end
    end
  endtask

  task automatic measure(output int d0, output int d1, output int d2);
    d0 = 0; d1 = 0; d2 = 0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (o_strb[0] && d0 == 0) d0 = k;
      if (o_strb[1] && d1 == 0) d1 = k;
      if (o_strb[2] && d2 == 0) d2 = k;
      if (d0 != 0 && d1 != 0 && d2 != 0) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] exp_s;
    int sweep_bad, all_bad, all_between, gap_bad, bad;
    int d, d0, d1, d2;

    n_pass = 0; n_checks = 0;
    rst_clk = 1'b0; i_en = 1'b0; i_sync = 1'b0;
    i_cfg_valid = 1'b0; i_cfg_ch = 2'd0; i_cfg_div = 8'd0;

    tbl[0]  = '{1,    3'b111}; tbl[1]  = '{2,    3'b000};
    tbl[2]  = '{41,   3'b100}; tbl[3]  = '{42,   3'b010};
    tbl[4]  = '{81,   3'b100}; tbl[5]  = '{83,   3'b010};
    tbl[6]  = '{121,  3'b100}; tbl[7]  = '{124,  3'b010};
    tbl[8]  = '{165,  3'b011}; tbl[9]  = '{329,  3'b011};
    tbl[10] = '{821,  3'b011}; tbl[11] = '{1601, 3'b100};
    tbl[12] = '{1640, 3'b000}; tbl[13] = '{1641, 3'b111};

    for (int k = 0; k < 3; k++) @(posedge clk);
    #1;
    check("rst_strb",  int'(o_strb), 0);
    check("rst_ready", int'(o_cfg_ready), 1);
    check("rst_err",   int'(o_cfg_err), 0);
    check("rst_all",   int'(o_strb_all), 0);

    // Defaults from reset release through the first full coincidence.
    rst_clk = 1'b1; i_en = 1'b1;
    sweep_bad = 0; all_bad = 0; all_between = 0;
    for (int c = 1; c <= 1641; c++) begin
      step();
      obs[c] = o_strb;
      exp_s = {((c - 1) % 40 == 0), ((c - 1) % 41 == 0), ((c - 1) % 164 == 0)};
      if (o_strb !== exp_s) sweep_bad++;
      if (o_strb_all !== (&exp_s)) all_bad++;
      if (c > 1 && c < 1641 && o_strb_all) all_between++;
    end
    check("sweep_strb", sweep_bad, 0);
    check("sweep_all", all_bad, 0);
    check("all_between", all_between, 0);
    for (int i = 0; i < 14; i++)
      check($sformatf("tbl_cyc%0d", tbl[i].cyc), int'(obs[tbl[i].cyc]), int'(tbl[i].strb));

    // Enable gap with ch2 at count 20.
    for (int k = 0; k < 20; k++) step();
    i_en = 1'b0; gap_bad = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (o_strb != 3'b000) gap_bad++;
    end
    check("gap_quiet", gap_bad, 0);
    i_en = 1'b1;
    next_strb(2, 60, d);
    check("gap_resume_cycles", 10 + d, 30);

    // Sync wins over en=0.
    i_en = 1'b0; i_sync = 1'b1;
    step();
    check("sync_strb", int'(o_strb), 7);
    check("sync_all", int'(o_strb_all), 1);
    i_sync = 1'b0; i_en = 1'b1;
    measure(d0, d1, d2);
    check("sync_d0", d0, 164); check("sync_d1", d1, 41); check("sync_d2", d2, 40);

    // Reprogram ch1 to 10 while its count is 5.
    i_sync = 1'b1; step(); i_sync = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("cfg_ready_idle", int'(o_cfg_ready), 1);
    i_cfg_valid = 1'b1; i_cfg_ch = 2'd1; i_cfg_div = 8'd10;
    step();
    i_cfg_valid = 1'b0;
    check("cfg_ready_drop", int'(o_cfg_ready), 0);
    next_strb(1, 60, d);
    check("commit_dist", 1 + d, 36);
    check("cfg_ready_commit", int'(o_cfg_ready), 0);
    step();
    check("cfg_ready_back", int'(o_cfg_ready), 1);
    next_strb(1, 20, d);
    check("new_period1", 1 + d, 10);
    next_strb(1, 20, d);
    check("new_period2", d, 10);

    // Out-of-range channel is rejected.
    i_cfg_valid = 1'b1; i_cfg_ch = 2'd3; i_cfg_div = 8'd7;
    step();
    i_cfg_valid = 1'b0;
    check("inv_err", int'(o_cfg_err), 1);
    check("inv_ready", int'(o_cfg_ready), 1);
    step();
    check("inv_err_pulse", int'(o_cfg_err), 0);
    i_sync = 1'b1; step(); i_sync = 1'b0;
    check("inv_sync_strb", int'(o_strb), 7);
    measure(d0, d1, d2);
    check("inv_d0", d0, 164); check("inv_d1", d1, 10); check("inv_d2", d2, 40);

    // Divisors 1 and 0 on ch0, committed through sync.
    for (int v = 1; v >= 0; v--) begin
      i_cfg_valid = 1'b1; i_cfg_ch = 2'd0; i_cfg_div = 8'(v);
      step();
      i_cfg_valid = 1'b0; i_sync = 1'b1;
      step();
      i_sync = 1'b0;
      check($sformatf("div%0d_sync", v), int'(o_strb), 7);
      bad = 0;
      for (int k = 0; k < 3; k++) begin
        step();
        if (!o_strb[0]) bad++;
      end
      check($sformatf("div%0d_every", v), bad, 0);
      check($sformatf("div%0d_ready", v), int'(o_cfg_ready), 1);
    end

    // Async reset with a request pending.
    i_cfg_valid = 1'b1; i_cfg_ch = 2'd2; i_cfg_div = 8'd5;
    step();
    i_cfg_valid = 1'b0;
    check("pend_ready", int'(o_cfg_ready), 0);
    #2 rst_clk = 1'b0;
    #1;
    check("arst_strb", int'(o_strb), 0);
    check("arst_ready", int'(o_cfg_ready), 1);
    check("arst_all", int'(o_strb_all), 0);
    @(posedge clk); #1;
    rst_clk = 1'b1;
    step();
    check("rel_cyc1", int'(o_strb), 7);
    measure(d0, d1, d2);
    check("rel_d0", d0, 164); check("rel_d1", d1, 41); check("rel_d2", d2, 40);
    check("rel_ready", int'(o_cfg_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
